// File: rtl/ps2_key_pkg.sv
// Shared constants, FSM encoding and event-word layout for the PS/2 key event decoder.
// Imported by the decoder top and the event FIFO.
package ps2_key_pkg;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;

    // Keyboard protocol chatter (BAT result, ACK, echo, resend, errors); not keys.
    localparam logic [7:0] BYTE_BAT    = 8'hAA;
    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_ECHO   = 8'hEE;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;
    localparam logic [7:0] BYTE_ERR0   = 8'h00;
    localparam logic [7:0] BYTE_ERR1   = 8'hFF;

    localparam int EVT_W        = 10;
    localparam int EVT_REL      = 9;
    localparam int EVT_EXT      = 8;
    localparam int EVT_CODE_MSB = 7;
    localparam int EVT_CODE_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } dec_state_e;

    function automatic logic is_chatter(input logic [7:0] b);
        return (b == BYTE_BAT)    || (b == BYTE_ACK)  || (b == BYTE_ECHO) ||
               (b == BYTE_RESEND) || (b == BYTE_ERR0) || (b == BYTE_ERR1);
    endfunction

    function automatic logic [EVT_W-1:0] make_event(input logic rel, input logic ext,
                                                    input logic [7:0] code);
        logic [EVT_W-1:0] w;
        w                            = '0;
        w[EVT_REL]                   = rel;
        w[EVT_EXT]                   = ext;
        w[EVT_CODE_MSB:EVT_CODE_LSB] = code;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with exact occupancy count; a push while full is accepted only
// when a pop happens in the same cycle, otherwise it is ignored (caller flags loss).
module sync_fifo
    import ps2_key_pkg::*;
#(
    parameter int WIDTH = EVT_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pops on an empty FIFO are ignored; a full FIFO frees its slot for a same-cycle push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Folds PS/2 E0/F0 prefixes into make/break key events, drops protocol chatter,
// and queues events for the processor behind a valid/ready port.
module ps2_key_event_decoder
    import ps2_key_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int PREFIX_TIMEOUT = 50000
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     key_valid,
    input  logic [7:0]               key_byte,
    // Handshake: the head event transfers on a rising clock edge where evt_valid and
    // evt_ready are both high; evt_data is stable while evt_valid is high and not popped,
    // and evt_ready is ignored while evt_valid is low.
    output logic                     evt_valid,
    output logic [EVT_W-1:0]         evt_data,
    input  logic                     evt_ready,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic [1:0]               fsm_state
);

    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

    dec_state_e       state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             overflow_q, overflow_d;
    logic             emit, emit_rel, emit_ext;
    logic             timeout_hit;
    logic             fifo_full, fifo_empty, pop;
    logic [EVT_W-1:0] emit_word;

    assign timeout_hit = (state_q != ST_IDLE) && !key_valid && (tmo_q == TMO_LAST);

    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_rel = 1'b0;
        emit_ext = 1'b0;
        if (timeout_hit) begin
            state_d = ST_IDLE;
        end else if (key_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (key_byte == BYTE_E0) begin
                        state_d = ST_GOT_E0;
                    end else if (key_byte == BYTE_F0) begin
                        state_d = ST_GOT_F0;
                    end else if (!is_chatter(key_byte)) begin
                        emit = 1'b1;
                    end
                end
                ST_GOT_E0: begin
                    if (key_byte == BYTE_F0) begin
                        state_d = ST_GOT_E0F0;
                    end else if (key_byte != BYTE_E0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_GOT_F0: begin
                    // An E0 after F0 restarts the sequence; the stale F0 is forgotten.
                    if (key_byte == BYTE_E0) begin
                        state_d = ST_GOT_E0;
                    end else if (key_byte != BYTE_F0) begin
                        emit     = 1'b1;
                        emit_rel = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_GOT_E0F0: begin
                    if (key_byte == BYTE_E0) begin
                        state_d = ST_GOT_E0;
                    end else if (key_byte != BYTE_F0) begin
                        emit     = 1'b1;
                        emit_rel = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if ((state_q == ST_IDLE) || key_valid || timeout_hit) begin
            tmo_d = '0;
        end
    end

    assign emit_word = make_event(emit_rel, emit_ext, key_byte);
    assign pop       = evt_valid && evt_ready;

    always_comb begin
        overflow_d = overflow_q;
        if (clear_overflow) begin
            overflow_d = 1'b0;
        end
        if (emit && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_ni      (resetn),
        .push_i      (emit),
        .push_data_i (emit_word),
        .pop_i       (pop),
        .pop_data_o  (evt_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (evt_count)
    );

    assign evt_valid = !fifo_empty;
    assign overflow  = overflow_q;
    assign fsm_state = state_q;

endmodule
